// File: rtl/wb_stream_writer_master.sv
// Wishbone read master that streams a ring buffer into a FIFO in fixed-size bursts.
// Optional bus-error handling is enabled with the macro WB_STREAM_WRITER_ERR_EN;
// without it wbm_err_i is ignored and err_o is tied low.
module wb_stream_writer_master #(
  parameter int unsigned WB_AW   = 32,
  parameter int unsigned WB_DW   = 32,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  // Wishbone master
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  // FIFO write side
  output logic [WB_DW-1:0]   fifo_d,
  output logic               fifo_wr,
  input  logic [FIFO_AW:0]   fifo_cnt,
  // Configuration
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic               err_o
);

  localparam int unsigned      ByteShift = $clog2(WB_DW / 8);
  localparam logic [WB_AW-1:0] BeatBytes = WB_AW'(WB_DW / 8);
  localparam logic [FIFO_AW:0] FifoDepth = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [2:0]       CtiInc    = 3'b010;
  localparam logic [2:0]       CtiEnd    = 3'b111;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [WB_AW-1:0] idx_q, idx_d;
  logic [WB_AW-1:0] left_q, left_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic             cyc_q, cyc_d;
  logic [2:0]       cti_q, cti_d;
  logic             err_q, err_d;

  logic [FIFO_AW:0] fifo_free;
  logic [WB_AW-1:0] fifo_free_w;
  logic [WB_AW-1:0] ring_left;
  logic [WB_AW-1:0] burst_len;
  logic [WB_AW-1:0] idx_inc;
  logic             burst_go;
  logic             beat_ack;
  logic             beat_err;

  assign fifo_free   = FifoDepth - fifo_cnt;
  assign fifo_free_w = WB_AW'(fifo_free);
  assign ring_left   = buf_size - idx_q;
  // Clip the burst at the ring end so a burst never wraps.
  assign burst_len   = (burst_size < ring_left) ? burst_size : ring_left;
  assign idx_inc     = idx_q + WB_AW'(1);

  assign burst_go = (state_q == StIdle) && enable && (buf_size != '0) && (burst_size != '0) &&
                    (fifo_free_w >= burst_size) && !err_q;

`ifdef WB_STREAM_WRITER_ERR_EN
  // err wins over a simultaneous ack.
  assign beat_err = cyc_q & wbm_err_i;
  assign beat_ack = cyc_q & wbm_ack_i & ~wbm_err_i;
`else
  assign beat_err = 1'b0;
  assign beat_ack = cyc_q & wbm_ack_i;
`endif

  // Next-state logic: burst launch, per-beat advance and termination.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    left_d  = left_q;
    adr_d   = adr_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (!enable) begin
          // Disabled ring restarts from its base and clears a pending error.
          idx_d = '0;
          err_d = 1'b0;
        end
        if (burst_go) begin
          state_d = StBurst;
          cyc_d   = 1'b1;
          left_d  = burst_len;
          adr_d   = start_adr + (idx_q << ByteShift);
          cti_d   = (burst_len == WB_AW'(1)) ? CtiEnd : CtiInc;
        end
      end
      StBurst: begin
        if (beat_err) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          cti_d   = 3'b000;
          err_d   = 1'b1;
        end else if (beat_ack) begin
          idx_d  = (idx_inc == buf_size) ? '0 : idx_inc;
          adr_d  = adr_q + BeatBytes;
          left_d = left_q - WB_AW'(1);
          if (left_q == WB_AW'(1)) begin
            state_d = StIdle;
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
          end else begin
            cti_d = (left_q == WB_AW'(2)) ? CtiEnd : CtiInc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered bus outputs, synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      left_q  <= '0;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      adr_q   <= adr_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      err_q   <= err_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = cti_q;
  assign wbm_bte_o = 2'b00;
  assign busy      = cyc_q;

  // Read data goes straight to the FIFO in the ack cycle.
  assign fifo_d  = wbm_dat_i;
  assign fifo_wr = beat_ack & wb_rst_ni;

`ifdef WB_STREAM_WRITER_ERR_EN
  assign err_o = err_q;
  logic unused_rty;
  assign unused_rty = wbm_rty_i;
`else
  assign err_o = 1'b0;
  logic unused_ins;
  assign unused_ins = ^{wbm_rty_i, wbm_err_i, err_q};
`endif

endmodule

// File: tb/tb_wb_stream_writer_master.sv
// Scoreboard bench for wb_stream_writer_master: a random slave pushes the expected beat
// (from a ring/burst reference model) on every ack it gives; a negedge monitor pops on fifo_wr.
module tb_wb_stream_writer_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int FAW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] dat_i = '0;
  logic          ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [DW-1:0] fifo_d;
  logic          fifo_wr;
  logic [FAW:0]  fifo_cnt = '0;
  logic          enable = 1'b0;
  logic [AW-1:0] start_adr = '0;
  logic [AW-1:0] buf_size = '0;
  logic [AW-1:0] burst_size = '0;
  logic          busy, err_o;

  always #5 clk = ~clk;

  wb_stream_writer_master #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
    .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .err_o(err_o)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [31:0] dat;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_wr = 0;
  int    ack_cnt = 0;
  int    err_at = -1;
  int    p_wait = 0;
  int    p_rty = 0;
  bit    slave_on = 1'b1;
  bit    fc_rand = 1'b0;
  bit    chk_drop = 1'b0;
  // Reference model: word index in the ring and beats left in the current burst.
  int    buf_sz = 0, burst_sz = 0, m_idx = 0, m_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t model_next(input logic [31:0] d);
    beat_t b;
    if (m_left == 0) m_left = (burst_sz < buf_sz - m_idx) ? burst_sz : buf_sz - m_idx;
    b.adr  = start_adr + 32'(m_idx * 4);
    b.cti  = (m_left == 1) ? 3'b111 : 3'b010;
    b.dat  = d;
    m_left = m_left - 1;
    m_idx  = (m_idx + 1 == buf_sz) ? 0 : m_idx + 1;
    return b;
  endfunction

  // Slave: random waits/retries, acks push the expected beat.
  always @(posedge clk) begin
    #1;
    ack = 1'b0; rty = 1'b0; err = 1'b0;
    dat_i = $urandom;
    if (slave_on && stb && rst_n) begin
      int r;
      r = $urandom_range(99);
      if (r < p_wait) begin
      end else if (r < p_wait + p_rty) begin
        rty = 1'b1;
      end else begin
        ack = 1'b1;
        if (ack_cnt == err_at) begin
          err = 1'b1;
          err_at = -1;
`ifdef WB_STREAM_WRITER_ERR_EN
          m_left = 0;
`else
          exp_q.push_back(model_next(dat_i));
`endif
        end else begin
          exp_q.push_back(model_next(dat_i));
        end
        ack_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (fc_rand) fifo_cnt = 5'($urandom_range(16));
  end

  // Monitor: compare every FIFO write against the scoreboard.
  always @(negedge clk) begin
    if (chk_drop) begin
      chk("cyc_after_last", {31'd0, cyc}, 32'd0);
      chk_drop = 1'b0;
    end
    if (rst_n && fifo_wr) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got adr %0h, required no write", adr);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_adr", adr, e.adr);
        chk("beat_cti", {29'd0, cti}, {29'd0, e.cti});
        chk("beat_dat", fifo_d, e.dat);
        if (e.cti == 3'b111) chk_drop = 1'b1;
      end
    end
  end

  task automatic wait_wr(input int target, input string name);
    int k = 0;
    while (n_wr < target && k < 3000) begin @(negedge clk); #1; k++; end
    n_cmp++;
    if (n_wr < target) begin
      n_bad++;
      $display("FAIL %s: writes got %0d required %0d", name, n_wr, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (cyc && k < 3000) begin @(negedge clk); #1; k++; end
    chk(name, {31'd0, cyc}, 32'd0);
  endtask

  task automatic config_ring(input logic [31:0] sa, input int bs, input int bu);
    start_adr = sa; buf_sz = bs; burst_sz = bu;
    buf_size = 32'(bs); burst_size = 32'(bu);
    m_idx = 0; m_left = 0;
  endtask

  // Disable, let the current burst finish, and realign the model with the ring base.
  task automatic flush(input string name);
    enable = 1'b0;
    wait_idle(name);
    @(negedge clk); #1;
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_idx = 0; m_left = 0;
  endtask

  initial begin
    int base;
    bit seen;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_cti", {29'd0, cti}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    rst_n = 1'b1;

    // Basic: two bursts then wrap back to 0x100
    config_ring(32'h100, 8, 4);
    enable = 1'b1;
    wait_wr(12, "basic_wait");
    flush("basic_idle");

    // Backpressure
    fifo_cnt = 5'd13;
    enable = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); #1; if (cyc) seen = 1'b1; end
    chk("bp_held", {31'd0, seen}, 32'd0);
    fifo_cnt = 5'd12;
    chk("bp_same_cycle", {31'd0, cyc}, 32'd0);
    @(negedge clk); #1;
    chk("bp_rise", {31'd0, cyc}, 32'd1);
    fifo_cnt = '0;
    wait_wr(n_wr + 4, "bp_wait");
    flush("bp_idle");

    // Partial bursts with waits and retries
    config_ring(32'h100, 6, 4);
    p_wait = 30; p_rty = 15;
    enable = 1'b1;
    wait_wr(n_wr + 18, "partial_wait");
    flush("partial_idle");

    // Randomized ring geometries with random FIFO fill
    for (int it = 0; it < 6; it++) begin
      logic [31:0] sa;
      sa = $urandom;
      sa = sa & 32'h000F_FFFC;
      config_ring(sa, $urandom_range(1, 12), $urandom_range(1, 8));
      fc_rand = 1'b1;
      enable = 1'b1;
      wait_wr(n_wr + 15, "rand_wait");
      enable = 1'b0;
      fc_rand = 1'b0;
      flush("rand_idle");
      fifo_cnt = '0;
    end
    p_wait = 0; p_rty = 0;

    // Enable dropped after beat 1
    config_ring(32'h200, 8, 4);
    base = n_wr;
    enable = 1'b1;
    wait_wr(base + 1, "drop_wait");
    enable = 1'b0;
    wait_idle("drop_idle");
    chk("drop_beats", 32'(n_wr - base), 32'd4);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); #1; if (cyc) seen = 1'b1; end
    chk("drop_no_restart", {31'd0, seen}, 32'd0);
    flush("drop_flush");

    // Reset after beat 2
    enable = 1'b1;
    wait_wr(n_wr + 2, "rst_mid_wait");
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_mid_adr", adr, 32'd0);
    chk("rst_mid_cti", {29'd0, cti}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    m_idx = 0; m_left = 0;
    @(negedge clk); #1;

    // Error on beat 3
    config_ring(32'h100, 8, 4);
    base = n_wr;
    err_at = ack_cnt + 2;
    enable = 1'b1;
`ifdef WB_STREAM_WRITER_ERR_EN
    wait_wr(base + 2, "err_wait");
    repeat (3) begin @(negedge clk); #1; end
    chk("err_flag", {31'd0, err_o}, 32'd1);
    chk("err_beats", 32'(n_wr - base), 32'd2);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); #1; if (cyc) seen = 1'b1; end
    chk("err_blocks", {31'd0, seen}, 32'd0);
    enable = 1'b0;
    @(negedge clk); #1;
    chk("err_clear", {31'd0, err_o}, 32'd0);
    m_idx = 0; m_left = 0;
    enable = 1'b1;
    wait_wr(n_wr + 4, "err_restart");
    flush("err_idle");
`else
    wait_wr(base + 4, "err_wait");
    enable = 1'b0;
    wait_idle("err_idle");
    chk("err_ignored_beats", 32'(n_wr - base), 32'd4);
    chk("err_flag_tied", {31'd0, err_o}, 32'd0);
    flush("err_flush");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
